// File: rtl/axis_count_packetizer_if.sv
// AXI-Stream beat channel carrying the serialised package-count words.
interface axis_count_packetizer_if #(
  parameter int BEAT_W = 3
);
  logic              tvalid;
  logic              tready;
  logic [BEAT_W-1:0] tdata;
  logic              tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_count_packetizer.sv
// Periodic package counter whose counts are queued in a small FIFO and
// streamed MSB-first as BEAT_W-wide AXI-Stream beats, with overflow drop count.
module axis_count_packetizer #(
  parameter int PERIOD_W   = 8,
  parameter int CNT_W      = 6,
  parameter int BEAT_W     = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int LAST_MODE  = 0,
  parameter int DROP_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [PERIOD_W-1:0]     period,
  input  logic [CNT_W-1:0]        cnt_limit,
  axis_count_packetizer_if.master m_axis,
  output logic [DROP_W-1:0]       drop_cnt
);
  localparam int BEATS   = CNT_W / BEAT_W;
  localparam int BEAT_CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int PTR_CW  = PTR_W + 1;
  localparam int WORD_W  = CNT_W + 1;

  typedef enum logic {S_IDLE, S_SEND} state_t;

  logic [PERIOD_W-1:0] r_tick_cnt;
  logic [CNT_W-1:0]    r_pkg_cnt;
  logic [WORD_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W:0]      r_wr_ptr;
  logic [PTR_W:0]      r_rd_ptr;
  logic [DROP_W-1:0]   r_drop_cnt;
  state_t              r_state;
  logic [CNT_W-1:0]    r_shift;
  logic                r_frame_end;
  logic [BEAT_CW-1:0]  r_beat;

  logic                w_tick;
  logic [CNT_W-1:0]    w_pkg_inc;
  logic                w_frame_end;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;
  logic                w_shift;
  logic                w_last_beat;
  logic                w_hs;
  logic [WORD_W-1:0]   w_head;
  state_t              w_state_next;

  // >= rather than == so a period shrink below the running count ticks at once
  assign w_tick = start && (r_tick_cnt >= period);

  always_ff @(posedge clk) begin
    if (rst || !start || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + PERIOD_W'(1);
    end
  end

  assign w_pkg_inc   = r_pkg_cnt + CNT_W'(1);
  assign w_frame_end = (w_pkg_inc == cnt_limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pkg_cnt <= '0;
    end else if (w_tick) begin
      r_pkg_cnt <= w_frame_end ? '0 : w_pkg_inc;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                   (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
  assign w_push  = w_tick && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= {w_frame_end, w_pkg_inc};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_CW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_CW'(1);
      end
      if (w_tick && !w_push && !(&r_drop_cnt)) begin
        r_drop_cnt <= r_drop_cnt + DROP_W'(1);
      end
    end
  end

  assign w_last_beat = (r_beat == BEAT_CW'(BEATS - 1));
  assign w_hs        = (r_state == S_SEND) && m_axis.tready;

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_shift      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SEND;
        end
      end
      S_SEND: begin
        if (w_hs) begin
          if (!w_last_beat) begin
            w_shift = 1'b1;
          end else if (!w_empty) begin
            w_pop = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_frame_end <= 1'b0;
      r_beat      <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_pop) begin
        r_shift     <= w_head[CNT_W-1:0];
        r_frame_end <= w_head[CNT_W];
        r_beat      <= '0;
      end else if (w_shift) begin
        r_shift <= r_shift << BEAT_W;
        r_beat  <= r_beat + BEAT_CW'(1);
      end
    end
  end

  assign m_axis.tvalid = (r_state == S_SEND);
  assign m_axis.tdata  = r_shift[CNT_W-1 -: BEAT_W];
  assign m_axis.tlast  = (r_state == S_SEND) && w_last_beat &&
                         ((LAST_MODE == 0) || r_frame_end);
  assign drop_cnt      = r_drop_cnt;
endmodule

// File: tb/tb_axis_count_packetizer.sv
// Bench for axis_count_packetizer: directed scenarios on three configurations
// plus randomized traffic against an order-preserving word scoreboard.
`timescale 1ns/1ps
module tb_axis_count_packetizer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, tready;
  logic [7:0] period;
  logic [5:0] cnt_limit;
  logic [7:0] cnt_limit8;
  logic [7:0] drop0, drop1, drop2;
  int         n_cmp = 0;
  int         n_err = 0;
  int         sel = 0;

  axis_count_packetizer_if #(.BEAT_W(3)) ax0 ();
  axis_count_packetizer_if #(.BEAT_W(3)) ax1 ();
  axis_count_packetizer_if #(.BEAT_W(2)) ax2 ();
  assign ax0.tready = tready;
  assign ax1.tready = tready;
  assign ax2.tready = tready;

  axis_count_packetizer #(.LAST_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .period(period), .cnt_limit(cnt_limit),
    .m_axis(ax0), .drop_cnt(drop0));
  axis_count_packetizer #(.LAST_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .period(period), .cnt_limit(cnt_limit),
    .m_axis(ax1), .drop_cnt(drop1));
  axis_count_packetizer #(.CNT_W(8), .BEAT_W(2), .FIFO_DEPTH(8), .LAST_MODE(1)) dut2 (
    .clk(clk), .rst(rst), .start(start), .period(period), .cnt_limit(cnt_limit8),
    .m_axis(ax2), .drop_cnt(drop2));

  logic       s_tv, s_tl;
  logic [2:0] s_td;
  logic [7:0] s_drop;
  always_comb begin
    s_tv = ax0.tvalid; s_tl = ax0.tlast; s_td = ax0.tdata; s_drop = drop0;
    if (sel == 1) begin
      s_tv = ax1.tvalid; s_tl = ax1.tlast; s_td = ax1.tdata; s_drop = drop1;
    end
  end

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; start = 1'b0; tready = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      rst = 1'b0; start = (j < 12); period = 8'd0; tready = 1'b0;
    end
    #1;
    if ({ax0.tvalid, drop0} !== {1'b1, 8'd7}) begin
      n_err++; $display("FAIL pre_reset_dut0: tvalid/drop got %b/%0d want 1/7", ax0.tvalid, drop0);
    end
    n_cmp++;
    if (drop2 !== 8'd3) begin n_err++; $display("FAIL pre_reset_dut2: drop got %0d want 3", drop2); end
    n_cmp++;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    if ({ax0.tvalid, ax0.tlast, ax0.tdata, drop0} !== 13'd0) begin
      n_err++; $display("FAIL reset_dut0: v/l/d/drop got %b/%b/%0d/%0d want all 0", ax0.tvalid, ax0.tlast, ax0.tdata, drop0);
    end
    n_cmp++;
    if ({ax1.tvalid, ax1.tlast, ax1.tdata, drop1} !== 13'd0) begin
      n_err++; $display("FAIL reset_dut1: v/l/d/drop got %b/%b/%0d/%0d want all 0", ax1.tvalid, ax1.tlast, ax1.tdata, drop1);
    end
    n_cmp++;
    if ({ax2.tvalid, ax2.tlast, ax2.tdata, drop2} !== 12'd0) begin
      n_err++; $display("FAIL reset_dut2: v/l/d/drop got %b/%b/%0d/%0d want all 0", ax2.tvalid, ax2.tlast, ax2.tdata, drop2);
    end
    n_cmp++;
  endtask

  task automatic test_basic();
    int         words [7] = '{1, 2, 3, 4, 5, 1, 2};
    int         rises [$];
    int         nb = 0;
    logic       prev_tv = 1'b0;
    logic [5:0] wv;
    logic [2:0] exp_d;
    logic       exp_l;
    do_reset();
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      start = 1'b1; period = 8'd10; cnt_limit = 6'd5; tready = 1'b1;
      #1;
      if (ax0.tvalid && !prev_tv) rises.push_back(j);
      prev_tv = ax0.tvalid;
      if (ax0.tvalid && nb < 14) begin
        wv    = 6'(words[nb / 2]);
        exp_d = (nb % 2 == 0) ? wv[5:3] : wv[2:0];
        exp_l = (nb % 2 == 1);
        if ({ax0.tdata, ax0.tlast} !== {exp_d, exp_l}) begin
          n_err++; $display("FAIL basic_beat%0d: data/last got %0d/%b want %0d/%b", nb, ax0.tdata, ax0.tlast, exp_d, exp_l);
        end
        n_cmp++;
        if (exp_l) $display("basic: word %0d value %0d at cycle %0d", nb / 2, wv, j);
        nb++;
      end
    end
    if (nb < 14) begin n_err++; $display("FAIL basic_count: beats got %0d want 14", nb); end
    n_cmp++;
    if (rises.size() < 7) begin
      n_err++; $display("FAIL basic_rises: tvalid rises got %0d want 7", rises.size());
    end else begin
      if (rises[0] != 12) begin n_err++; $display("FAIL basic_latency: first tvalid cycle got %0d want 12", rises[0]); end
      for (int k = 1; k < 7; k++) begin
        if (rises[k] - rises[k-1] != 11) begin
          n_err++; $display("FAIL basic_spacing%0d: gap got %0d want 11", k, rises[k] - rises[k-1]);
        end
        n_cmp++;
      end
    end
    n_cmp++;
  endtask

  task automatic test_frame_mode();
    int         nb = 0;
    logic [5:0] wv;
    logic [2:0] exp_d;
    logic       exp_l;
    do_reset();
    for (int j = 0; j < 80; j++) begin
      @(negedge clk);
      start = 1'b1; period = 8'd4; cnt_limit = 6'd3; tready = 1'b1;
      #1;
      if (ax1.tvalid && nb < 12) begin
        wv    = 6'((nb / 2) % 3 + 1);
        exp_d = (nb % 2 == 0) ? wv[5:3] : wv[2:0];
        exp_l = (nb % 2 == 1) && (wv == 6'd3);
        if ({ax1.tdata, ax1.tlast} !== {exp_d, exp_l}) begin
          n_err++; $display("FAIL frame_beat%0d: data/last got %0d/%b want %0d/%b", nb, ax1.tdata, ax1.tlast, exp_d, exp_l);
        end
        n_cmp++;
        if (nb % 2 == 1) $display("frame: word value %0d tlast %b", wv, ax1.tlast);
        nb++;
      end
    end
    if (nb < 12) begin n_err++; $display("FAIL frame_count: beats got %0d want 12", nb); end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    logic [5:0] wv;
    logic [2:0] exp_d;
    do_reset();
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      start = (j < 20); period = 8'd0; cnt_limit = 6'd0; tready = 1'b0;
      #1;
      if (j >= 2) begin
        if ({ax0.tvalid, ax0.tdata, ax0.tlast} !== {1'b1, 3'd0, 1'b0}) begin
          n_err++; $display("FAIL bp_hold%0d: v/d/l got %b/%0d/%b want 1/0/0", j, ax0.tvalid, ax0.tdata, ax0.tlast);
        end
        n_cmp++;
      end
    end
    if (drop0 !== 8'd15) begin n_err++; $display("FAIL bp_drop: got %0d want 15", drop0); end
    n_cmp++;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      tready = 1'b1;
      #1;
      if (k < 10) begin
        wv    = 6'(k / 2 + 1);
        exp_d = (k % 2 == 0) ? wv[5:3] : wv[2:0];
        if ({ax0.tvalid, ax0.tdata, ax0.tlast} !== {1'b1, exp_d, k % 2 == 1}) begin
          n_err++; $display("FAIL bp_stream%0d: v/d/l got %b/%0d/%b want 1/%0d/%0d", k, ax0.tvalid, ax0.tdata, ax0.tlast, exp_d, k % 2);
        end
        if (k % 2 == 1) $display("backpressure: drained word %0d", wv);
      end else if (ax0.tvalid !== 1'b0) begin
        n_err++; $display("FAIL bp_end: tvalid got %b want 0", ax0.tvalid);
      end
      n_cmp++;
    end
  endtask

  task automatic test_drop_saturation();
    do_reset();
    for (int j = 0; j < 320; j++) begin
      @(negedge clk);
      start = 1'b1; period = 8'd0; cnt_limit = 6'd0; tready = 1'b0;
      #1;
      if (j >= 2 && j % 32 == 0) begin
        if ({ax0.tvalid, ax0.tdata} !== {1'b1, 3'd0}) begin
          n_err++; $display("FAIL sat_hold%0d: v/d got %b/%0d want 1/0", j, ax0.tvalid, ax0.tdata);
        end
        n_cmp++;
      end
      if (j == 300) begin
        if (drop0 !== 8'd255) begin n_err++; $display("FAIL sat_drop300: got %0d want 255", drop0); end
        n_cmp++;
      end
    end
    if (drop0 !== 8'd255) begin n_err++; $display("FAIL sat_drop_hold: got %0d want 255", drop0); end
    n_cmp++;
  endtask

  // Continues from the saturated state: word 1 is parked in the serialiser
  task automatic test_reset_mid_packet();
    int nb = 0;
    @(negedge clk); start = 1'b0; tready = 1'b1; #1;
    if ({ax0.tvalid, ax0.tdata, ax0.tlast} !== {1'b1, 3'd0, 1'b0}) begin
      n_err++; $display("FAIL mid_beat0: v/d/l got %b/%0d/%b want 1/0/0", ax0.tvalid, ax0.tdata, ax0.tlast);
    end
    n_cmp++;
    @(negedge clk); rst = 1'b1; #1;
    if ({ax0.tvalid, ax0.tdata, ax0.tlast} !== {1'b1, 3'd1, 1'b1}) begin
      n_err++; $display("FAIL mid_beat1: v/d/l got %b/%0d/%b want 1/1/1", ax0.tvalid, ax0.tdata, ax0.tlast);
    end
    n_cmp++;
    @(negedge clk); rst = 1'b0; #1;
    if ({ax0.tvalid, ax0.tlast, ax0.tdata, drop0} !== 13'd0) begin
      n_err++; $display("FAIL mid_reset: v/l/d/drop got %b/%b/%0d/%0d want all 0", ax0.tvalid, ax0.tlast, ax0.tdata, drop0);
    end
    n_cmp++;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      start = 1'b1; period = 8'd3; cnt_limit = 6'd5; tready = 1'b1;
      #1;
      if (ax0.tvalid && nb < 2) begin
        if ({ax0.tdata, ax0.tlast} !== {3'(nb), nb == 1}) begin
          n_err++; $display("FAIL mid_restart%0d: d/l got %0d/%b want %0d/%0d", nb, ax0.tdata, ax0.tlast, nb, nb);
        end
        n_cmp++;
        nb++;
      end
    end
    if (nb < 2) begin n_err++; $display("FAIL mid_restart_count: beats got %0d want 2", nb); end
    n_cmp++;
  endtask

  task automatic test_param_sweep();
    int         nb = 0;
    logic [7:0] ev;
    logic [1:0] exp_d;
    logic       exp_l;
    do_reset();
    for (int j = 0; j < 1000 && nb < 724; j++) begin
      @(negedge clk);
      start = 1'b1; period = 8'd3; cnt_limit8 = 8'hB4; tready = 1'b1;
      #1;
      if (ax2.tvalid) begin
        ev    = 8'((nb / 4) % 180 + 1);
        exp_d = ev[7 - 2 * (nb % 4) -: 2];
        exp_l = (nb % 4 == 3) && (ev == 8'hB4);
        if ({ax2.tdata, ax2.tlast} !== {exp_d, exp_l}) begin
          n_err++; $display("FAIL sweep_beat%0d: d/l got %0d/%b want %0d/%b", nb, ax2.tdata, ax2.tlast, exp_d, exp_l);
        end
        n_cmp++;
        if (nb % 4 == 3 && nb / 4 >= 179) $display("sweep: word %0d value 0x%h tlast %b", nb / 4, ev, ax2.tlast);
        nb++;
      end
    end
    if (nb < 724) begin n_err++; $display("FAIL sweep_count: beats got %0d want 724", nb); end
    n_cmp++;
    if (drop2 !== 8'd0) begin n_err++; $display("FAIL sweep_drop: got %0d want 0", drop2); end
    n_cmp++;
  endtask

  task automatic test_random(input int which);
    logic [6:0] pushed [$];
    logic [6:0] w = 7'd0;
    logic [5:0] m_pkg = 6'd0;
    logic [5:0] v;
    logic [5:0] acc = 6'd0;
    int         m_tcnt = 0, delivered = 0, skipped = 0, nbeat = 0, exp_drop;
    logic       prev_stall = 1'b0, hold_l = 1'b0, found;
    logic [2:0] hold_d = 3'd0;
    sel = which;
    do_reset();
    cnt_limit = 6'($urandom_range(0, 20));
    period    = 8'($urandom_range(1, 6));
    for (int j = 0; j < 900; j++) begin
      @(negedge clk);
      if (j < 800) begin
        start  = ($urandom_range(0, 29) != 0);
        tready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 63) == 0) period = 8'($urandom_range(0, 6));
      end else begin
        start = 1'b0; tready = 1'b1;
      end
      #1;
      if (prev_stall) begin
        if ({s_tv, s_tl, s_td} !== {1'b1, hold_l, hold_d}) begin
          n_err++; $display("FAIL rand_hold%0d: v/l/d got %b/%b/%0d want 1/%b/%0d", j, s_tv, s_tl, s_td, hold_l, hold_d);
        end
        n_cmp++;
      end
      if (s_tv && tready) begin
        if (nbeat == 0) begin
          acc[5:3] = s_td;
          nbeat = 1;
          if (s_tl !== 1'b0) begin n_err++; $display("FAIL rand_first_last%0d: tlast got %b want 0", j, s_tl); end
          n_cmp++;
        end else begin
          acc[2:0] = s_td;
          nbeat = 0;
          found = 1'b0;
          while (pushed.size() > 0 && !found) begin
            w = pushed.pop_front();
            if (w[5:0] == acc) found = 1'b1;
            else skipped++;
          end
          delivered++;
          if (!found) begin n_err++; $display("FAIL rand_word%0d: got %0d, not among queued words", j, acc); end
          n_cmp++;
          if (found) begin
            if (s_tl !== ((which == 0) ? 1'b1 : w[6])) begin
              n_err++; $display("FAIL rand_last%0d: tlast got %b want %b", j, s_tl, (which == 0) ? 1'b1 : w[6]);
            end
            n_cmp++;
          end
        end
      end
      prev_stall = s_tv && !tready; hold_l = s_tl; hold_d = s_td;
      // Reference: one word per (period+1) enabled cycles, counting modulo cnt_limit
      if (start && m_tcnt >= int'(period)) begin
        v = m_pkg + 6'd1;
        pushed.push_back({v == cnt_limit, v});
        m_pkg  = (v == cnt_limit) ? 6'd0 : v;
        m_tcnt = 0;
      end else if (start) begin
        m_tcnt++;
      end else begin
        m_tcnt = 0;
      end
    end
    exp_drop = skipped + pushed.size();
    if (exp_drop > 255) exp_drop = 255;
    if (s_drop !== 8'(exp_drop)) begin n_err++; $display("FAIL rand_drop: got %0d want %0d", s_drop, exp_drop); end
    n_cmp++;
    if (s_tv !== 1'b0) begin n_err++; $display("FAIL rand_idle: tvalid got %b want 0", s_tv); end
    n_cmp++;
    $display("random dut%0d: %0d words delivered, %0d expected drops", which, delivered, exp_drop);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; tready = 1'b0; period = 8'd0; cnt_limit = 6'd0; cnt_limit8 = 8'd0;
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_frame_mode();
    test_backpressure();
    test_drop_saturation();
    test_reset_mid_packet();
    test_param_sweep();
    test_random(0);
    test_random(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
